// File: rtl/serial_tl_host.sv
// serial_tl_host: host-side peer of the chip's 1-bit serial TileLink port.
// Serializes tx words LSB first onto bits_in and reassembles bits_out into rx words.
module serial_tl_host #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         tx_valid,
   output logic         tx_ready,
   input  logic [W-1:0] tx_data,
   output logic         rx_valid,
   input  logic         rx_ready,
   output logic [W-1:0] rx_data,
   output logic         serial_in_valid,
   output logic         serial_in_bits,
   input  logic         serial_in_ready,
   input  logic         serial_out_valid,
   input  logic         serial_out_bits,
   output logic         serial_out_ready
);
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;
   typedef enum logic {RX_COLLECT, RX_FULL} rx_state_e;

   tx_state_e tx_state_q, tx_state_d;
   logic [W-1:0] shreg_q, shreg_d;
   logic [CW-1:0] txcnt_q, txcnt_d;

   rx_state_e rx_state_q, rx_state_d;
   logic [W-1:0] rshreg_q, rshreg_d;
   logic [W-1:0] rx_data_q, rx_data_d;
   logic [CW-1:0] rxcnt_q, rxcnt_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state_q <= TX_IDLE;
         shreg_q    <= '0;
         txcnt_q    <= '0;
         rx_state_q <= RX_COLLECT;
         rshreg_q   <= '0;
         rx_data_q  <= '0;
         rxcnt_q    <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         shreg_q    <= shreg_d;
         txcnt_q    <= txcnt_d;
         rx_state_q <= rx_state_d;
         rshreg_q   <= rshreg_d;
         rx_data_q  <= rx_data_d;
         rxcnt_q    <= rxcnt_d;
      end
   end

   // Bit on the lane comes straight from the shift register, so it holds while the chip stalls.
   always_comb begin
      tx_state_d      = tx_state_q;
      shreg_d         = shreg_q;
      txcnt_d         = txcnt_q;
      tx_ready        = tx_state_q == TX_IDLE;
      serial_in_valid = tx_state_q == TX_SHIFT;
      serial_in_bits  = serial_in_valid & shreg_q[0];
      if (tx_state_q == TX_IDLE) begin
         if (tx_valid) begin
            shreg_d    = tx_data;
            txcnt_d    = '0;
            tx_state_d = TX_SHIFT;
         end
      end else if (serial_in_ready) begin
         shreg_d = shreg_q >> 1;
         txcnt_d = (txcnt_q == LAST) ? '0 : txcnt_q + CW'(1);
         tx_state_d = (txcnt_q == LAST) ? TX_IDLE : TX_SHIFT;
      end
   end

   // serial_out_ready depends on state alone, never on rx_ready.
   always_comb begin
      rx_state_d       = rx_state_q;
      rshreg_d         = rshreg_q;
      rx_data_d        = rx_data_q;
      rxcnt_d          = rxcnt_q;
      serial_out_ready = rx_state_q == RX_COLLECT;
      rx_valid         = rx_state_q == RX_FULL;
      rx_data          = rx_data_q;
      if (rx_state_q == RX_COLLECT) begin
         if (serial_out_valid) begin
            rshreg_d = {serial_out_bits, rshreg_q[W-1:1]};
            rxcnt_d  = (rxcnt_q == LAST) ? '0 : rxcnt_q + CW'(1);
            if (rxcnt_q == LAST) begin
               rx_data_d  = rshreg_d;
               rx_state_d = RX_FULL;
            end
         end
      end else if (rx_ready) begin
         rx_state_d = RX_COLLECT;
      end
   end
endmodule

// File: tb/tb_serial_tl_host.sv
// tb_serial_tl_host: scoreboard bench for serial_tl_host with directed chip stimulus and loopback.
module tb_serial_tl_host;
   logic        clock = 0;
   logic        reset = 1;
   logic        tx_valid = 0;
   logic        tx_ready;
   logic [31:0] tx_data = '0;
   logic        rx_valid;
   logic        rx_ready = 0;
   logic [31:0] rx_data;
   logic        serial_in_valid, serial_in_bits, serial_in_ready;
   logic        serial_out_valid, serial_out_bits, serial_out_ready;
   logic        loop = 0, chip_ir = 1, chip_ov = 0, chip_ob = 0;
   int          checks = 0, errors = 0;
   logic [31:0] exp_tx[$], exp_rx[$];
   logic [31:0] tw;
   int          tcnt = 0;

   assign serial_in_ready  = loop ? serial_out_ready : chip_ir;
   assign serial_out_valid = loop ? serial_in_valid : chip_ov;
   assign serial_out_bits  = loop ? serial_in_bits : chip_ob;

   serial_tl_host #(.W(32)) dut (
      .clock(clock), .reset(reset),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .serial_in_valid(serial_in_valid), .serial_in_bits(serial_in_bits),
      .serial_in_ready(serial_in_ready), .serial_out_valid(serial_out_valid),
      .serial_out_bits(serial_out_bits), .serial_out_ready(serial_out_ready)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset_values();
      check("rst_tx_ready", tx_ready, 1);
      check("rst_sin_valid", serial_in_valid, 0);
      check("rst_sin_bits", serial_in_bits, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_sout_ready", serial_out_ready, 1);
   endtask

   task automatic send_tx(input logic [31:0] w, input bit to_rx);
      int t = 0;
      exp_tx.push_back(w);
      if (to_rx) exp_rx.push_back(w);
      tx_valid = 1;
      tx_data  = w;
      while (!tx_ready && t < 200) begin cyc(); t++; end
      if (t >= 200) check("tx_accept_timeout", t, 0);
      cyc();
      tx_valid = 0;
   endtask

   task automatic send_rx(input logic [31:0] w);
      exp_rx.push_back(w);
      for (int i = 0; i < 32; i++) begin
         int t = 0;
         chip_ov = 1;
         chip_ob = w[i];
         while (!serial_out_ready && t < 200) begin cyc(); t++; end
         if (t >= 200) check("rx_bit_timeout", t, 0);
         cyc();
      end
      chip_ov = 0;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_tx.size() != 0 || exp_rx.size() != 0) && t < 2000) begin cyc(); t++; end
      check("drain_tx_q", exp_tx.size(), 0);
      check("drain_rx_q", exp_rx.size(), 0);
   endtask

   // Serial bits observed on handshakes are regrouped into words and matched in order.
   always @(negedge clock) begin
      if (reset) tcnt = 0;
      else if (serial_in_valid && serial_in_ready) begin
         tw[tcnt] = serial_in_bits;
         tcnt++;
         if (tcnt == 32) begin
            tcnt = 0;
            if (exp_tx.size() == 0) check("tx_q_empty", exp_tx.size(), 1);
            else check("tx_word", tw, exp_tx.pop_front());
         end
      end
   end

   always @(negedge clock) begin
      if (!reset && rx_valid && rx_ready) begin
         if (exp_rx.size() == 0) check("rx_q_empty", exp_rx.size(), 1);
         else check("rx_word", rx_data, exp_rx.pop_front());
      end
   end

   initial begin
      logic [31:0] d, held;
      int cnt, taken, stall;
      cyc(); cyc();
      check_reset_values();
      reset = 0;
      cyc();

      // 1: plain word, chip always ready
      d = 32'hA5A5_0F0F;
      exp_tx.push_back(d);
      tx_valid = 1;
      tx_data  = d;
      cyc();
      tx_valid = 0;
      for (int i = 0; i < 32; i++) begin
         check("t1_valid", serial_in_valid, 1);
         check("t1_bit", serial_in_bits, d[i]);
         cyc();
      end
      check("t1_tx_ready", tx_ready, 1);
      check("t1_idle_valid", serial_in_valid, 0);

      // 2: chip stalls 5 cycles on bit 7
      d = 32'h3C96_E187;
      exp_tx.push_back(d);
      tx_valid = 1;
      tx_data  = d;
      cyc();
      tx_valid = 0;
      cnt = 0; taken = 0; stall = 0;
      while (serial_in_valid && cnt < 200) begin
         chip_ir = !(taken == 7 && stall < 5);
         if (!chip_ir) begin
            stall++;
            check("t2_hold", serial_in_bits, d[7]);
         end else taken++;
         cnt++;
         cyc();
      end
      chip_ir = 1;
      check("t2_beats", cnt, 37);

      // 3: chip sends DEADBEEF, consumer not ready
      send_rx(32'hDEAD_BEEF);
      check("t3_rx_valid", rx_valid, 1);
      check("t3_rx_data", rx_data, 32'hDEAD_BEEF);
      check("t3_sout_ready", serial_out_ready, 0);

      // 4: consumer stalls 10 cycles while chip keeps offering a bit
      chip_ov = 1;
      chip_ob = 1;
      held = rx_data;
      for (int i = 0; i < 10; i++) begin
         check("t4_sout_ready", serial_out_ready, 0);
         check("t4_rx_stable", rx_data, held);
         cyc();
      end
      rx_ready = 1;
      cyc();
      rx_ready = 0;
      check("t4_released", serial_out_ready, 1);
      send_rx(32'h1234_5679);
      check("t4_rx_data", rx_data, 32'h1234_5679);
      rx_ready = 1;
      cyc();
      check("t4_back", rx_valid, 0);

      // 5: full-duplex loopback
      loop = 1;
      for (int i = 0; i < 100; i++) send_tx($urandom, 1);
      drain();
      loop = 0;

      // 6: reset after 13 bits in both directions
      rx_ready = 0;
      tx_valid = 1;
      tx_data  = 32'hFFFF_FFFF;
      cyc();
      tx_valid = 0;
      for (int i = 0; i < 13; i++) begin
         chip_ov = 1;
         chip_ob = 1;
         cyc();
      end
      chip_ov = 0;
      reset = 1;
      cyc();
      check_reset_values();
      reset = 0;
      cyc();
      rx_ready = 1;
      fork
         send_tx(32'h0000_8001, 0);
         send_rx(32'h0001_0002);
      join
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
